muxn_stream: RTL and testbench

- Parametrised N-channel, W-bit-wide registered multiplexer with a valid/ready handshake on every input and on the output; the next generation of the team's 1-bit combinational 4:1 mux.
- Selects one input channel per cycle, either from an explicit select input or by round-robin arbitration.
- Registers the chosen word so that output data and source index are stable while stalled.
- Sits between multiple producers and a single consumer in datapath and simulation tops.

---
 rtl/muxn_stream.sv | 108 ++++++++++
 tb/tb_muxn_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muxn_stream.sv
// N-channel registered stream mux with valid/ready on every port; select or round-robin channel choice.
// Round-robin arbitration and its pointer are built only when MUXN_STREAM_RR_EN is defined.

module muxn_stream_lane #(
  parameter int IDX = 0,
  parameter int SW  = 2
) (
  input  logic          grant,
  input  logic [SW-1:0] cand,
  output logic          ready
);
  assign ready = grant && (cand == SW'(IDX));
endmodule

module muxn_stream #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           rr_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src
);

  logic [N-1:0][W-1:0] data_a;
  logic                load;
  logic                grant;
  logic                cand_vld;
  logic [SW-1:0]       cand;

  assign load  = !out_valid || out_ready;
  assign grant = load && cand_vld && !reset;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign data_a[i] = in_data[i*W +: W];
    muxn_stream_lane #(.IDX(i), .SW(SW)) u_lane (
      .grant (grant),
      .cand  (cand),
      .ready (in_ready[i])
    );
  end

`ifdef MUXN_STREAM_RR_EN
  logic [SW-1:0] ptr;
  int            rr_j;

  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    rr_j     = 0;
    if (rr_mode) begin
      // Scan from the far end back towards ptr so the nearest requester wins.
      for (int k = N-1; k >= 0; k--) begin
        rr_j = int'(ptr) + k;
        if (rr_j >= N) rr_j = rr_j - N;
        if (in_valid[rr_j]) begin
          cand_vld = 1'b1;
          cand     = SW'(rr_j);
        end
      end
    end else if (int'(sel) < N && in_valid[sel]) begin
      cand_vld = 1'b1;
      cand     = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (grant && rr_mode) ptr <= (int'(cand) == N-1) ? '0 : cand + SW'(1);
  end
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;

  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    if (int'(sel) < N && in_valid[sel]) begin
      cand_vld = 1'b1;
      cand     = sel;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      // Without a candidate the held word is consumed but data/src keep their last values.
      out_valid <= cand_vld;
      if (cand_vld) begin
        out_data <= data_a[cand];
        out_src  <= cand;
      end
    end
  end

endmodule

// File: tb/tb_muxn_stream.sv
// Directed bench for muxn_stream: reset, select mode, backpressure, invalid select, round robin / select-only.
// A second instance with N=6 exercises select values beyond the channel count.

module tb_muxn_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;

  logic [5:0]  in_valid6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic [2:0]  sel6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_src6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muxn_stream #(.N(4), .W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  muxn_stream #(.N(6), .W(8)) u_dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid6),
    .in_data   (in_data6),
    .in_ready  (in_ready6),
    .sel       (sel6),
    .rr_mode   (rr_mode),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_data  (out_data6),
    .out_src   (out_src6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".src"},   64'(out_src),   64'(s));
  endtask

  logic [1:0] exp_src [5];

  initial begin
    reset = 1'b1; in_valid = 4'b1111; in_data = 32'h44332211; sel = 2'd0;
    rr_mode = 1'b0; out_ready = 1'b1;
    in_valid6 = 6'h3f; in_data6 = 48'h665544332211; sel6 = 3'd0;

    // Reset: all requesters valid, nothing may be granted
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst.in_ready", 64'(in_ready), 64'h0);
      chk("rst.in_ready6", 64'(in_ready6), 64'h0);
      chk_out("rst", 1'b0, 8'h00, 2'd0);
    end
    reset = 1'b0; in_valid = 4'b0000; in_valid6 = 6'h0;
    cyc();

    // Select mode: ch2 carries 0xA5
    sel = 2'd2; in_valid = 4'b0100; set_d(2, 8'hA5);
    #1 chk("sel.in_ready", 64'(in_ready), 64'b0100);
    cyc();
    in_valid = 4'b0000;
    #1 chk_out("sel.out", 1'b1, 8'hA5, 2'd2);
    chk("sel.ready_idle", 64'(in_ready), 64'h0);
    cyc();
    chk_out("sel.drain", 1'b0, 8'hA5, 2'd2);

    // Backpressure: 0x3C held for 3 stalled cycles while ch1 data changes
    sel = 2'd1; in_valid = 4'b0010; set_d(1, 8'h3C);
    cyc();
    out_ready = 1'b0; set_d(1, 8'hFF);
    #1 chk("bp.in_ready0", 64'(in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp.in_ready", 64'(in_ready), 64'h0);
      chk_out("bp.hold", 1'b1, 8'h3C, 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 64'(in_ready), 64'b0010);
    cyc();
    chk_out("bp.nobubble", 1'b1, 8'hFF, 2'd1);
    in_valid = 4'b0000;
    cyc();
    chk("bp.drain", 64'(out_valid), 64'h0);

    // Back-to-back select transfers from different channels
    sel = 2'd0; in_valid = 4'b1001; set_d(0, 8'h11); set_d(3, 8'h77);
    cyc();
    chk_out("b2b.0", 1'b1, 8'h11, 2'd0);
    sel = 2'd3;
    #1 chk("b2b.ready3", 64'(in_ready), 64'b1000);
    cyc();
    chk_out("b2b.3", 1'b1, 8'h77, 2'd3);

    // Invalid select: selected channel not valid
    sel = 2'd3; in_valid = 4'b0111;
    #1 chk("inv.in_ready", 64'(in_ready), 64'h0);
    cyc();
    chk("inv.out_valid", 64'(out_valid), 64'h0);
    in_valid = 4'b0000;

    // Select index beyond N on the 6-channel instance
    in_valid6 = 6'h3f; sel6 = 3'd6;
    #1 chk("n6.sel6_ready", 64'(in_ready6), 64'h0);
    cyc();
    chk("n6.sel6_valid", 64'(out_valid6), 64'h0);
    sel6 = 3'd5;
    #1 chk("n6.sel5_ready", 64'(in_ready6), 64'b100000);
    cyc();
    chk("n6.sel5_valid", 64'(out_valid6), 64'h1);
    chk("n6.sel5_data", 64'(out_data6), 64'h66);
    chk("n6.sel5_src", 64'(out_src6), 64'd5);
    sel6 = 3'd7;
    #1 chk("n6.sel7_ready", 64'(in_ready6), 64'h0);
    cyc();
    chk("n6.sel7_valid", 64'(out_valid6), 64'h0);
    in_valid6 = 6'h0;

    // Reset mid-stall discards the held word
    sel = 2'd2; in_valid = 4'b0100; set_d(2, 8'h5A);
    cyc();
    out_ready = 1'b0; reset = 1'b1;
    #1 chk("rststall.in_ready", 64'(in_ready), 64'h0);
    cyc();
    chk_out("rststall", 1'b0, 8'h00, 2'd0);
    reset = 1'b0; out_ready = 1'b1; in_valid = 4'b0000;
    in_data = 32'h44332211;
    cyc();

`ifdef MUXN_STREAM_RR_EN
    // Round robin over all four channels from ptr=0
    rr_mode = 1'b1; in_valid = 4'b1111;
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr4.in_ready", 64'(in_ready), 64'(4'b0001 << exp_src[i]));
      cyc();
      chk_out("rr4.out", 1'b1, 8'(8'h11 + 8'h11 * exp_src[i]), exp_src[i]);
    end
    rr_mode = 1'b0; in_valid = 4'b0000; reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    // Sparse requesters 1 and 3 alternate
    rr_mode = 1'b1; in_valid = 4'b1010;
    exp_src = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr2.src", 64'(out_src), 64'(exp_src[i]));
    end
`else
    // Select-only build ignores rr_mode
    rr_mode = 1'b1; sel = 2'd0; in_valid = 4'b1111;
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      #1 chk("norr.in_ready", 64'(in_ready), 64'b0001);
      cyc();
      chk_out("norr.out", 1'b1, 8'h11, exp_src[i]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
